id_ex_stage: RTL and testbench

ID/EX pipeline stage for the five-stage MIPS core: registers decoded operands, register numbers and control from ID into EX, and owns the pipeline's stall/bubble decisions. Detects load-use hazards and sequences multi-cycle EX operations (MULT/DIV) with a small counter FSM. Its `ex_rs`/`ex_rt` outputs are the register numbers the forwarding unit compares against EX/MEM and MEM/WB destinations; its `ex_done` output tells the EX/MEM register whether to capture or insert a bubble.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 20 ++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: field widths, ALU
// opcodes, control bundle with its bubble value, and ID/EX FSM states.
package pipeline_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_MULT = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_DIV  = 4'd6;

  // Decoded control carried from ID into EX.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic multi;
  } ctrl_t;

  // A bubble never writes a register, touches memory or starts a multi-cycle op.
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction currently in ID. Pure combinational so it can be reused for
// other in-ID hazard checks.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i &
                      ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Owns the stall/bubble decisions for the front of
// the pipe and sequences multi-cycle EX operations (MULT/DIV).
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int ALU_OP_W    = pipeline_pkg::ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic                id_multi,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                flush,
  output logic                stall_if_id,
  output logic                ex_valid,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic                ex_multi,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_done,
  output logic                ex_busy
);

  localparam int              CNT_W    = $clog2(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_CYCLES - 1);

  typedef struct packed {
    logic                valid;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    ctrl_t               ctrl;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d, id_pkt;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             last_cycle;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.ctrl.mem_read),
    .ex_rd_i       (ex_q.rd),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .load_use_o    (load_use)
  );

  // Pack the ID fields; an empty ID slot becomes an all-zero bubble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    id_pkt = '0;
    if (id_valid) begin
      id_pkt.valid           = 1'b1;
      id_pkt.rs              = id_rs;
      id_pkt.rt              = id_rt;
      id_pkt.rd              = id_rd;
      id_pkt.rs_data         = id_rs_data;
      id_pkt.rt_data         = id_rt_data;
      id_pkt.imm             = id_imm;
      id_pkt.ctrl.reg_write  = id_reg_write;
      id_pkt.ctrl.mem_read   = id_mem_read;
      id_pkt.ctrl.mem_write  = id_mem_write;
      id_pkt.ctrl.mem_to_reg = id_mem_to_reg;
      id_pkt.ctrl.alu_src    = id_alu_src;
      id_pkt.ctrl.multi      = id_multi;
      id_pkt.alu_op          = id_alu_op;
    end
  end

  // A multi-cycle op spends its first EX cycle with the FSM still in IDLE,
  // so the final cycle is the one where BUSY has counted up to CNT_LAST.
  assign last_cycle  = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
  assign ex_done     = ex_q.valid & (~ex_q.ctrl.multi | last_cycle) & ~flush;
  assign ex_busy     = ex_q.valid & ex_q.ctrl.multi & ~ex_done;
  assign stall_if_id = ~flush & (ex_busy | load_use);

  // EX register next value: flush > busy hold > load-use bubble > capture ID.
  always_comb begin
    ex_d = id_pkt;
    if (flush) begin
      ex_d = '0;
    end else if (ex_busy) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end
  end

  // Multi-cycle sequencer next state; flush abandons any op in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_q.valid && ex_q.ctrl.multi) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pipeline register and FSM state; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_reg_write  = ex_q.ctrl.reg_write;
  assign ex_mem_read   = ex_q.ctrl.mem_read;
  assign ex_mem_write  = ex_q.ctrl.mem_write;
  assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign ex_alu_src    = ex_q.ctrl.alu_src;
  assign ex_multi      = ex_q.ctrl.multi;
  assign ex_alu_op     = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes the expected EX-side
// view for each cycle, a monitor pops and compares mid-cycle.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int MC = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [REG_W-1:0]    id_rs, id_rt, id_rd;
  logic [DATA_W-1:0]   id_rs_data, id_rt_data, id_imm;
  logic                id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_multi;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                flush;
  logic                stall_if_id, ex_valid;
  logic [REG_W-1:0]    ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0]   ex_rs_data, ex_rt_data, ex_imm;
  logic                ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_multi;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_done, ex_busy;

  id_ex_stage #(.MULT_CYCLES(MC), .ALU_OP_W(ALU_OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_multi(id_multi),
    .id_alu_op(id_alu_op), .flush(flush), .stall_if_id(stall_if_id), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_multi(ex_multi),
    .ex_alu_op(ex_alu_op), .ex_done(ex_done), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic              reg_write;
    logic              mem_read;
    logic              multi;
    logic              done;
    logic              busy;
    logic              stall;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } item_t;

  item_t sb_q[$];
  event  sample_ev;
  int    n_checks = 0;
  int    n_pass   = 0;

  localparam obs_t Z = '0;

  function automatic obs_t mk(input logic v, input int rs, input int rt, input int rd,
                              input logic [31:0] d, input logic rw, input logic mr,
                              input logic mu, input logic dn, input logic bs, input logic st);
    obs_t o;
    o.valid = v; o.rs = 5'(rs); o.rt = 5'(rt); o.rd = 5'(rd); o.rs_data = d;
    o.reg_write = rw; o.mem_read = mr; o.multi = mu;
    o.done = dn; o.busy = bs; o.stall = st;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("v=%0b rs=%0d rt=%0d rd=%0d rsd=%h rw=%0b mr=%0b mu=%0b done=%0b busy=%0b stall=%0b",
                     o.valid, o.rs, o.rt, o.rd, o.rs_data, o.reg_write, o.mem_read, o.multi,
                     o.done, o.busy, o.stall);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.valid = ex_valid; o.rs = ex_rs; o.rt = ex_rt; o.rd = ex_rd; o.rs_data = ex_rs_data;
    o.reg_write = ex_reg_write; o.mem_read = ex_mem_read; o.multi = ex_multi;
    o.done = ex_done; o.busy = ex_busy; o.stall = stall_if_id;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
  endtask

  // Monitor: pops one expectation per mid-cycle sample or explicit request.
  initial begin
    item_t it;
    forever begin
      @(negedge clk or sample_ev);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check(it.name, sample(), it.v);
      end
    end
  end

  task automatic expect_obs(input string name, input obs_t v);
    item_t it;
    it.name = name;
    it.v    = v;
    sb_q.push_back(it);
  endtask

  // One pipeline cycle: register expectation, then advance past the next edge.
  task automatic cyc(input string name, input obs_t v);
    expect_obs(name, v);
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                        input logic [31:0] d, input logic rw, input logic mr, input logic mu);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_rs_data = d; id_rt_data = d + 32'h1; id_imm = 32'h4;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    id_mem_to_reg = mr; id_alu_src = mr; id_multi = mu;
    id_alu_op = mu ? ALU_MULT : ALU_ADD;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t mult_busy, mult_done;
    mult_busy = mk(1, 2, 3, 0, 32'h22, 0, 0, 1, 0, 1, 1);
    mult_done = mk(1, 2, 3, 0, 32'h22, 0, 0, 1, 1, 0, 0);

    rst_n = 1'b0; flush = 1'b0; nop();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", Z);
    rst_n = 1'b1;

    // lw $5 then dependent add: one bubble, one stall cycle.
    set_id(1, 1, 5, 5, 32'h100, 1, 1, 0);  cyc("lu_lw_in_id", Z);
    set_id(1, 5, 7, 6, 32'h55, 1, 0, 0);   cyc("lu_stall", mk(1, 1, 5, 5, 32'h100, 1, 1, 0, 1, 0, 1));
    cyc("lu_bubble", Z);
    // lw $0 in ID while the add sits in EX.
    set_id(1, 1, 0, 0, 32'h100, 1, 1, 0);  cyc("lu_add_in_ex", mk(1, 5, 7, 6, 32'h55, 1, 0, 0, 1, 0, 0));
    set_id(1, 0, 7, 6, 32'h0, 1, 0, 0);    cyc("lw0_no_stall", mk(1, 1, 0, 0, 32'h100, 1, 1, 0, 1, 0, 0));

    // MULT then ADD: busy three cycles, done on the fourth, ADD follows.
    set_id(1, 2, 3, 0, 32'h22, 0, 0, 1);   cyc("add0_in_ex", mk(1, 0, 7, 6, 32'h0, 1, 0, 0, 1, 0, 0));
    set_id(1, 8, 9, 10, 32'h88, 1, 0, 0);
    cyc("mult_busy0", mult_busy);
    cyc("mult_busy1", mult_busy);
    cyc("mult_busy2", mult_busy);
    cyc("mult_done", mult_done);
    // Second MULT enters right behind the ADD, then is flushed at cnt=1.
    set_id(1, 2, 3, 0, 32'h22, 0, 0, 1);   cyc("add_after_mult", mk(1, 8, 9, 10, 32'h88, 1, 0, 0, 1, 0, 0));
    set_id(1, 8, 9, 10, 32'h88, 1, 0, 0);  cyc("fl_mult_first", mult_busy);
    flush = 1'b1;                          cyc("fl_at_cnt1", mk(1, 2, 3, 0, 32'h22, 0, 0, 1, 0, 1, 0));
    flush = 1'b0;

    // Back-to-back multi ops; the first one also proves the FSM left BUSY.
    set_id(1, 4, 3, 0, 32'h44, 0, 0, 1);   cyc("fl_bubble", Z);
    set_id(1, 6, 3, 0, 32'h66, 0, 0, 1);
    cyc("b2b_a_busy0", mk(1, 4, 3, 0, 32'h44, 0, 0, 1, 0, 1, 1));
    cyc("b2b_a_busy1", mk(1, 4, 3, 0, 32'h44, 0, 0, 1, 0, 1, 1));
    cyc("b2b_a_busy2", mk(1, 4, 3, 0, 32'h44, 0, 0, 1, 0, 1, 1));
    cyc("b2b_a_done",  mk(1, 4, 3, 0, 32'h44, 0, 0, 1, 1, 0, 0));
    nop();
    cyc("b2b_b_busy0", mk(1, 6, 3, 0, 32'h66, 0, 0, 1, 0, 1, 1));
    cyc("b2b_b_busy1", mk(1, 6, 3, 0, 32'h66, 0, 0, 1, 0, 1, 1));
    cyc("b2b_b_busy2", mk(1, 6, 3, 0, 32'h66, 0, 0, 1, 0, 1, 1));
    set_id(1, 1, 5, 5, 32'h100, 1, 1, 0);
    cyc("b2b_b_done",  mk(1, 6, 3, 0, 32'h66, 0, 0, 1, 1, 0, 0));

    // Flush coincident with a load-use hazard: flush wins, no stall.
    set_id(1, 5, 7, 6, 32'h55, 1, 0, 0);
    flush = 1'b1;                          cyc("fl_lu_no_stall", mk(1, 1, 5, 5, 32'h100, 1, 1, 0, 0, 0, 0));
    flush = 1'b0; nop();                   cyc("fl_lu_bubble", Z);
    cyc("fl_lu_no_repeat", Z);

    // Asynchronous reset while the MULT is at cnt=2.
    set_id(1, 2, 3, 0, 32'h22, 0, 0, 1);   cyc("r_mult_id", Z);
    nop();
    cyc("r_busy0", mult_busy);
    cyc("r_busy1", mult_busy);
    expect_obs("r_busy2", mult_busy);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    expect_obs("rst_async", Z);
    ->sample_ev;
    @(posedge clk);
    #1;
    cyc("rst_hold", Z);
    rst_n = 1'b1;

    // After release the FSM is IDLE with cnt=0: a full-length MULT again.
    set_id(1, 2, 3, 0, 32'h22, 0, 0, 1);   cyc("pr_mult_id", Z);
    nop();
    cyc("pr_busy0", mult_busy);
    cyc("pr_busy1", mult_busy);
    cyc("pr_busy2", mult_busy);
    cyc("pr_done", mult_done);
    cyc("pr_empty", Z);

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
